csa_iter_mul: RTL
=================

// Module: csa_iter_mul
// PURPOSE
//   Iterative RV64M multiplier for MUL/MULH/MULHSU/MULHU. Each cycle it retires STEP multiplier bits:
//   STEP partial products are folded into a carry-save accumulator through a 3:2/4:2 CSA row.
//   A single carry-propagate add and sign fix-up run at the end.
//   Sits beside the ALU in EX and uses a valid/ready handshake with a tag passthrough.
// PARAMETERS
//   XLEN   64  operand/result width; must be a multiple of STEP
//   STEP   2   multiplier bits consumed per CALC cycle (1,2,4)
//   TAG_W  5   width of the opaque tag (destination reg) carried with the op
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      block can accept a request
//   op         in   2      00 MUL(low), 01 MULH(s*s), 10 MULHSU(s*u), 11 MULHU(u*u)
//   a          in   XLEN   multiplicand (rs1)
//   b          in   XLEN   multiplier (rs2)
//   tag_in     in   TAG_W  tag, returned unchanged with the result
//   kill       in   1      flush: abort any in-flight op
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   result     out  XLEN   low half (MUL) or high half (MULH*) of the 2*XLEN product
//   tag_out    out  TAG_W  tag of the op in result
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; tag_out=0;
//     accumulators and counter cleared.
//   FSM: IDLE -> LOAD -> CALC (XLEN/STEP cycles) -> FINAL -> DONE.
//   Accept: a transfer occurs in the cycle where in_valid & in_ready are both high (cycle T).
//     in_ready = (state==IDLE) | (state==DONE & out_ready).
//     DONE with out_ready & in_valid retires the old op and accepts the new one in the same cycle.
//   LOAD: signed operand selection follows op: a is signed for 01/10; b is signed for 01 only.
//     Registers |a| and |b| as XLEN-bit unsigned (|-2^(XLEN-1)| = 2^(XLEN-1), no overflow).
//     Registers neg = sa^sb and the op/tag; clears sum/carry (2*XLEN bits each); cnt = XLEN/STEP.
//   CALC: per cycle, STEP partial products (|a| << k) & {XLEN{b_k}} at the current shift are added
//     into sum/carry via the CSA row. b shifts right by STEP and cnt decrements.
//     Leaves CALC when cnt reaches 0.
//   FINAL: p = sum + carry (2*XLEN CPA); p = neg ? -p : p; result = op==00 ? p[XLEN-1:0] : p[2XLEN-1:XLEN].
//   DONE: out_valid=1; result and tag_out are stable until out_ready.
//     Goes to IDLE, or to LOAD on a back-to-back accept.
//   Latency: out_valid rises at T + XLEN/STEP + 2 (64/2 -> T+34).
//   MUL ignores signedness: the low half is identical, so neg is forced to 0 when op==00.
//   kill: highest priority. From any state the FSM goes to IDLE on the next edge; out_valid drops to 0.
//     A same-cycle in_valid is not accepted (in_ready forced 0 while kill=1).
//   Requests while busy are not accepted (in_ready=0); the upstream stage holds operands.
//   Reset mid-operation: immediate return to reset values; no result is produced.
//   Operands a/b/op/tag are sampled only at accept; later changes have no effect.
// CONFIGURATION
//   MUL_EARLY_EXIT_EN defined: CALC exits to FINAL in the cycle its shifted b becomes 0.
//     Latency is then T + 2 + ceil(msb(|b|)+1 / STEP), minimum T+2 when |b|==0.
//     Results are bit-identical to the non-early-exit build.
//   Not defined: CALC always runs exactly XLEN/STEP cycles; latency is fixed.
// TESTING  (XLEN=64, STEP=2, macro undefined unless stated)
//   MUL 3*5, tag 7 -> out_valid at T+34, result=15, tag_out=7; in_ready low T+1..T+33.
//   MULH a=-1, b=-1 -> result=0; MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE.
//   MULHSU a=0x8000_0000_0000_0000, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF;
//     MULH of the same operands -> result=0xFFFF_FFFF_FFFF_FFFF.
//   Hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable.
//     Then out_ready=1 with in_valid=1 -> same-cycle accept, next result at +34.
//   kill asserted at T+10 -> out_valid never rises, state IDLE at T+11.
//     rst_n pulsed low at T+20 of another op -> all outputs at reset values asynchronously.
//   MUL_EARLY_EXIT_EN: MUL 7*3 -> out_valid at T+3; b=0 -> T+2; random 10k ops match reference model.

Source files
------------

// File: rtl/csa_iter_mul_if.sv
// Request/response bundle for csa_iter_mul: operand handshake, flush, result handshake and busy.
interface csa_iter_mul_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag_in;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output in_valid, op, a, b, tag_in, kill, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );

  modport slave (
    input  in_valid, op, a, b, tag_in, kill, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );
endinterface

// File: rtl/csa_iter_mul.sv
// csa_iter_mul: iterative RV64M MUL/MULH/MULHSU/MULHU, STEP bits per cycle into a carry-save accumulator.
// Optional MUL_EARLY_EXIT_EN: CALC ends as soon as the remaining multiplier bits are all zero.
module csa_iter_mul #(
  parameter int XLEN  = 64,
  parameter int STEP  = 2,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  csa_iter_mul_if.slave bus
);
  localparam int PW    = 2 * XLEN;
  localparam int NCALC = XLEN / STEP;
  localparam int CNT_W = $clog2(NCALC + 1);

  // Operand load is done on the accept edge itself, so the first CALC cycle is T+1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d, load_tgt_s;

  logic [PW-1:0]    mcand_q, sum_q, carry_q;
  logic [XLEN-1:0]  mplier_q, mplier_nx_s;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q, tag_out_q;
  logic [XLEN-1:0]  result_q, result_d;
  logic             out_valid_q, busy_q;

  logic             in_ready_s, accept_s, calc_exit_s;
  logic             sa_s, sb_s, neg_s;
  logic [XLEN-1:0]  a_abs_s, b_abs_s;
  logic [PW-1:0]    row_sum_s, row_carry_s, pp_s, tmp_s;
  logic [PW-1:0]    prod_s, prod_fix_s;
`ifdef MUL_EARLY_EXIT_EN
  logic             b_zero_s;
`endif

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    logic [PW-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PW-2:0], 1'b0};
  endfunction

  assign in_ready_s = !bus.kill &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;

  // Sign/magnitude of the incoming operands; MUL treats both as unsigned.
  always_comb begin
    sa_s    = bus.a[XLEN-1] && ((bus.op == 2'b01) || (bus.op == 2'b10));
    sb_s    = bus.b[XLEN-1] && (bus.op == 2'b01);
    a_abs_s = sa_s ? -bus.a : bus.a;
    b_abs_s = sb_s ? -bus.b : bus.b;
    neg_s   = (sa_s ^ sb_s) && (bus.op != 2'b00);
  end

  // One CSA row: STEP chained 3:2 stages folding the partial products into sum/carry.
  always_comb begin
    row_sum_s   = sum_q;
    row_carry_s = carry_q;
    pp_s        = '0;
    tmp_s       = '0;
    for (int k = 0; k < STEP; k++) begin
      pp_s        = (mcand_q << k) & {PW{mplier_q[k]}};
      tmp_s       = csa_sum(row_sum_s, row_carry_s, pp_s);
      row_carry_s = csa_carry(row_sum_s, row_carry_s, pp_s);
      row_sum_s   = tmp_s;
    end
  end

  assign mplier_nx_s = mplier_q >> STEP;

`ifdef MUL_EARLY_EXIT_EN
  assign b_zero_s    = (b_abs_s == '0);
  assign calc_exit_s = (mplier_nx_s == '0) || (cnt_q == CNT_W'(1));
  assign load_tgt_s  = b_zero_s ? S_FINAL : S_CALC;
`else
  assign calc_exit_s = (cnt_q == CNT_W'(1));
  assign load_tgt_s  = S_CALC;
`endif

  // Final carry-propagate add, sign fix-up and half select.
  always_comb begin
    prod_s = sum_q + carry_q;
    if (neg_q) begin
      prod_fix_s = -prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    if (op_q == 2'b00) begin
      result_d = prod_fix_s[XLEN-1:0];
    end else begin
      result_d = prod_fix_s[PW-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) state_d = load_tgt_s;
          else          state_d = S_IDLE;
        end
        S_CALC: begin
          if (calc_exit_s) state_d = S_FINAL;
          else             state_d = S_CALC;
        end
        S_FINAL: state_d = S_DONE;
        S_DONE: begin
          if (accept_s)           state_d = load_tgt_s;
          else if (bus.out_ready) state_d = S_IDLE;
          else                    state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      op_q        <= 2'b00;
      tag_q       <= '0;
      result_q    <= '0;
      tag_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept_s) begin
        mcand_q  <= {{XLEN{1'b0}}, a_abs_s};
        mplier_q <= b_abs_s;
        sum_q    <= '0;
        carry_q  <= '0;
        cnt_q    <= CNT_W'(NCALC);
        neg_q    <= neg_s;
        op_q     <= bus.op;
        tag_q    <= bus.tag_in;
      end else if (state_q == S_CALC) begin
        mcand_q  <= mcand_q << STEP;
        mplier_q <= mplier_nx_s;
        sum_q    <= row_sum_s;
        carry_q  <= row_carry_s;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
      if ((state_q == S_FINAL) && !bus.kill) begin
        result_q  <= result_d;
        tag_out_q <= tag_q;
      end
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_out   = tag_out_q;
  assign bus.busy      = busy_q;
endmodule
